// File: rtl/fft_pkg.sv
// Shared constants, phase codes and the DW-bit reduction used by the stage-1 radix-2 SDF butterfly.
// Build option FFT_BF_SAT_EN: reductions saturate instead of wrapping.
package fft_pkg;
  localparam int DW    = 19;
  localparam int WW    = 10;
  localparam int FRAC  = 8;
  localparam int DEPTH = 16;
  localparam int RND   = 128;
  // Product/sum width for the complex multiply: DW + WW + 1
  localparam int PW    = DW + WW + 1;

  localparam logic [1:0] PH_IDLE    = 2'b00;
  localparam logic [1:0] PH_FIRST   = 2'b01;
  localparam logic [1:0] PH_SECOND  = 2'b10;
  localparam logic [1:0] PH_WAITING = 2'b11;

  typedef logic signed [DW-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  function automatic sample_t reduce_dw(input logic signed [PW-1:0] v);
`ifdef FFT_BF_SAT_EN
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = PW'((1 <<< (DW-1)) - 1);
    lo = -hi - PW'(1);
    if (v > hi)      return hi[DW-1:0];
    else if (v < lo) return lo[DW-1:0];
    else             return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction
endpackage

// File: rtl/fft_bf16_stage_if.sv
// Bus between the stage-1 controller and the stage-1 butterfly, and from the butterfly to stage 2.
interface fft_bf16_stage_if;
  import fft_pkg::*;
  logic [1:0]           state;
  logic signed [DW-1:0] data_in_r;
  logic signed [DW-1:0] data_in_i;
  logic signed [WW-1:0] WN_r;
  logic signed [WW-1:0] WN_i;
  logic                 valid_o;
  logic signed [DW-1:0] data_out_r;
  logic signed [DW-1:0] data_out_i;
  logic [4:0]           idx_o;

  // No backpressure: inputs are consumed every cycle as qualified by state, and valid_o
  // marks data_out_*/idx_o as a sample for exactly that one cycle; the consumer takes every valid cycle.
  modport master (
    output state, data_in_r, data_in_i, WN_r, WN_i,
    input  valid_o, data_out_r, data_out_i, idx_o
  );
  modport slave (
    input  state, data_in_r, data_in_i, WN_r, WN_i,
    output valid_o, data_out_r, data_out_i, idx_o
  );
endinterface

// File: rtl/fft_cmul_q28.sv
// Combinational complex multiply of a DW-bit sample by a Q2.8 twiddle, round half up, reduce to DW bits.
module fft_cmul_q28
  import fft_pkg::*;
(
  input  logic signed [DW-1:0] tr,
  input  logic signed [DW-1:0] ti,
  input  logic signed [WW-1:0] wr,
  input  logic signed [WW-1:0] wi,
  output logic signed [DW-1:0] pr,
  output logic signed [DW-1:0] pi
);
  logic signed [PW-1:0] tr_x, ti_x, wr_x, wi_x;
  logic signed [PW-1:0] re_full, im_full, re_rnd, im_rnd;

  always_comb begin
    tr_x    = PW'(tr);
    ti_x    = PW'(ti);
    wr_x    = PW'(wr);
    wi_x    = PW'(wi);
    // Exact results fit in PW bits, so the truncated PW x PW products are exact
    re_full = tr_x * wr_x - ti_x * wi_x;
    im_full = tr_x * wi_x + ti_x * wr_x;
    re_rnd  = (re_full + PW'(RND)) >>> FRAC;
    im_rnd  = (im_full + PW'(RND)) >>> FRAC;
    pr      = reduce_dw(re_rnd);
    pi      = reduce_dw(im_rnd);
  end
endmodule

// File: rtl/fft_bf16_stage.sv
// Stage-1 radix-2 DIF SDF butterfly: 16-deep feedback delay line, add/sub, twiddle multiply, output register.
// Build option FFT_BF_SAT_EN selects saturating reductions (default: two's-complement wrap).
module fft_bf16_stage
  import fft_pkg::*;
(
  input logic              clk,
  input logic              rst,
  fft_bf16_stage_if.slave  bus
);
  cplx_t      dl [DEPTH];
  cplx_t      tail, din, push, result;
  sample_t    prod_r, prod_i;
  logic [4:0] out_cnt;
  logic       is_out;

  function automatic sample_t addsub(input sample_t a, input sample_t b, input logic sub);
    logic signed [DW:0] s;
    s = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    return reduce_dw(PW'(s));
  endfunction

  assign tail   = dl[DEPTH-1];
  assign din    = '{re: bus.data_in_r, im: bus.data_in_i};
  assign is_out = (bus.state == PH_FIRST) || (bus.state == PH_SECOND);

  fft_cmul_q28 u_cmul (
    .tr (tail.re),
    .ti (tail.im),
    .wr (bus.WN_r),
    .wi (bus.WN_i),
    .pr (prod_r),
    .pi (prod_i)
  );

  always_comb begin
    push   = din;
    result = '0;
    case (bus.state)
      PH_FIRST: begin
        result.re = addsub(tail.re, din.re, 1'b0);
        result.im = addsub(tail.im, din.im, 1'b0);
        push.re   = addsub(tail.re, din.re, 1'b1);
        push.im   = addsub(tail.im, din.im, 1'b1);
      end
      PH_SECOND: begin
        result.re = prod_r;
        result.im = prod_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
      bus.valid_o    <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
      bus.idx_o      <= '0;
      out_cnt        <= '0;
    end else begin
      if (bus.state != PH_IDLE) begin
        dl[0] <= push;
        for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
      end
      bus.valid_o <= is_out;
      if (is_out) begin
        bus.data_out_r <= result.re;
        bus.data_out_i <= result.im;
        bus.idx_o      <= out_cnt;
        out_cnt        <= out_cnt + 5'd1;
      end else if (bus.state == PH_WAITING) begin
        // A new frame is loading: restart output numbering
        bus.idx_o <= '0;
        out_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fft_bf16_stage.sv
// Bench for fft_bf16_stage: directed frame table, reset/IDLE sequences and random frames vs a frame-level model.
module tb_fft_bf16_stage;
  import fft_pkg::*;

  localparam int QW = 5 + 2*DW;
`ifdef FFT_BF_SAT_EN
  localparam int OVF_G = 262143;
`else
  localparam int OVF_G = -2;
`endif

  typedef struct {
    string name;
    int    x0, lo, x16, hi;
    int    ci[4];
    int    cr[4];
    int    cm[4];
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bf16_stage_if bus();
  fft_bf16_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [QW-1:0] exp_q[$];

  int tw_r[16] = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237};
  int tw_i[16] = '{0, -98, -181, -237, -256, -237, -181, -98, 0, 98, 181, 237, 256, 237, 181, 98};

  int fx_r[32], fx_i[32], fw_r[16], fw_i[16];
  int cap_r[32], cap_i[32];
  int cap_n;
  int sav_r[32], sav_i[32];
  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model: whole-frame arithmetic
  function automatic int red(input longint v);
    longint lim = longint'(1) <<< (DW-1);
`ifdef FFT_BF_SAT_EN
    if (v > lim - 1) return int'(lim - 1);
    if (v < -lim)    return int'(-lim);
    return int'(v);
`else
    longint m = v % (2*lim);
    if (m < 0)    m += 2*lim;
    if (m >= lim) m -= 2*lim;
    return int'(m);
`endif
  endfunction

  function automatic int rnd_s(input int bits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic model_frame();
    for (int n = 0; n < 16; n++)
      exp_q.push_back({5'(n), DW'(red(fx_r[n] + fx_r[n+16])), DW'(red(fx_i[n] + fx_i[n+16]))});
    for (int n = 0; n < 16; n++) begin
      longint dr, di, pr, pi;
      dr = red(fx_r[n] - fx_r[n+16]);
      di = red(fx_i[n] - fx_i[n+16]);
      pr = (dr * fw_r[n] - di * fw_i[n] + RND) >>> FRAC;
      pi = (dr * fw_i[n] + di * fw_r[n] + RND) >>> FRAC;
      exp_q.push_back({5'(16 + n), DW'(red(pr)), DW'(red(pi))});
    end
  endtask

  // scoreboard: every valid output must match the head of exp_q
  task automatic sb_sample();
    logic [QW-1:0] e;
    if (bus.valid_o) begin
      if (cap_n < 32) begin
        cap_r[cap_n] = $signed(bus.data_out_r);
        cap_i[cap_n] = $signed(bus.data_out_i);
        cap_n++;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("idx_o", bus.idx_o, e[QW-1 -: 5]);
        check("data_out_r", $signed(bus.data_out_r), $signed(e[2*DW-1 -: DW]));
        check("data_out_i", $signed(bus.data_out_i), $signed(e[DW-1:0]));
      end
    end
  endtask

  // driver: apply one cycle of inputs, then sample the registered outputs
  task automatic drive(input logic [1:0] st, input int dr, input int di, input int wr, input int wi);
    bus.state     = st;
    bus.data_in_r = DW'(dr);
    bus.data_in_i = DW'(di);
    bus.WN_r      = WW'(wr);
    bus.WN_i      = WW'(wi);
    @(posedge clk);
    #1;
    sb_sample();
  endtask

  task automatic run_frame();
    cap_n = 0;
    model_frame();
    for (int n = 0; n < 16; n++) begin
      drive(PH_WAITING, fx_r[n], fx_i[n], 0, 0);
      check("valid_waiting", bus.valid_o, 0);
    end
    for (int n = 0; n < 16; n++) begin
      drive(PH_FIRST, fx_r[16+n], fx_i[16+n], 0, 0);
      check("valid_first", bus.valid_o, 1);
    end
    for (int n = 0; n < 16; n++) begin
      drive(PH_SECOND, rnd_s(DW), rnd_s(DW), fw_r[n], fw_i[n]);
      check("valid_second", bus.valid_o, 1);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_frame(input int x0, input int lo, input int x16, input int hi);
    for (int n = 0; n < 32; n++) begin
      fx_r[n] = (n == 0) ? x0 : (n < 16) ? lo : (n == 16) ? x16 : hi;
      fx_i[n] = 0;
    end
    for (int n = 0; n < 16; n++) begin
      fw_r[n] = tw_r[n];
      fw_i[n] = tw_i[n];
    end
  endtask

  initial begin
    vecs[0] = '{"impulse",  1000,   0,     0,    0, '{0, 1, 16, 17},  '{1000, 0, 1000, 0}, '{0, 0, 0, 0}};
    vecs[1] = '{"constant",  256, 256,   256,  256, '{0, 15, 16, 31}, '{512, 512, 0, 0},   '{0, 0, 0, 0}};
    vecs[2] = '{"odd_half",  100, 100,  -100, -100, '{0, 18, 20, 24}, '{0, 141, 0, -200},  '{0, -141, -200, 0}};
    vecs[3] = '{"overflow", 262143, 0, 262143,   0, '{0, 1, 16, 17},  '{OVF_G, 0, 0, 0},   '{0, 0, 0, 0}};

    rst = 1'b1;
    bus.state = PH_IDLE;
    bus.data_in_r = '0; bus.data_in_i = '0; bus.WN_r = '0; bus.WN_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", bus.valid_o, 0);
    check("reset_data_r", $signed(bus.data_out_r), 0);
    check("reset_data_i", $signed(bus.data_out_i), 0);
    check("reset_idx", bus.idx_o, 0);
    rst = 1'b0;

    // directed frame table
    for (int v = 0; v < 4; v++) begin
      set_frame(vecs[v].x0, vecs[v].lo, vecs[v].x16, vecs[v].hi);
      run_frame();
      for (int k = 0; k < 4; k++) begin
        check({vecs[v].name, "_r"}, cap_r[vecs[v].ci[k]], vecs[v].cr[k]);
        check({vecs[v].name, "_i"}, cap_i[vecs[v].ci[k]], vecs[v].cm[k]);
      end
      if (v == 0) begin
        sav_r = cap_r;
        sav_i = cap_i;
      end
    end

    // reset on the 5th FIRST cycle, then a clean impulse frame
    set_frame(1000, 0, 0, 0);
    cap_n = 0;
    model_frame();
    for (int n = 0; n < 16; n++) drive(PH_WAITING, fx_r[n], fx_i[n], 0, 0);
    for (int n = 0; n < 4; n++)  drive(PH_FIRST, fx_r[16+n], fx_i[16+n], 0, 0);
    rst = 1'b1;
    exp_q.delete();
    drive(PH_FIRST, fx_r[20], fx_i[20], 0, 0);
    rst = 1'b0;
    check("midrst_valid", bus.valid_o, 0);
    check("midrst_data_r", $signed(bus.data_out_r), 0);
    check("midrst_data_i", $signed(bus.data_out_i), 0);
    check("midrst_idx", bus.idx_o, 0);
    run_frame();
    for (int n = 0; n < 32; n++) begin
      check("post_reset_impulse_r", cap_r[n], sav_r[n]);
      check("post_reset_impulse_i", cap_i[n], sav_i[n]);
    end

    // IDLE gap between two constant frames
    set_frame(256, 256, 256, 256);
    run_frame();
    sav_r = cap_r;
    sav_i = cap_i;
    for (int n = 0; n < 10; n++) begin
      drive(PH_IDLE, rnd_s(DW), rnd_s(DW), 0, 0);
      check("gap_valid", bus.valid_o, 0);
      check("gap_hold_r", $signed(bus.data_out_r), sav_r[31]);
      check("gap_hold_i", $signed(bus.data_out_i), sav_i[31]);
    end
    run_frame();
    for (int n = 0; n < 32; n++) begin
      check("gap_repeat_r", cap_r[n], sav_r[n]);
      check("gap_repeat_i", cap_i[n], sav_i[n]);
    end

    // random full-range frames and twiddles, with random IDLE gaps
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < 32; n++) begin
        fx_r[n] = rnd_s(DW);
        fx_i[n] = rnd_s(DW);
      end
      for (int n = 0; n < 16; n++) begin
        fw_r[n] = rnd_s(WW);
        fw_i[n] = rnd_s(WW);
      end
      run_frame();
      repeat ($urandom_range(0, 3)) begin
        drive(PH_IDLE, 0, 0, 0, 0);
        check("rand_gap_valid", bus.valid_o, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
